fract_render_sched: RTL and testbench
=====================================

Name: fract_render_sched

Overview:
Scheduler that sequences the fractal iteration core over every pixel of a frame and emits one write per pixel into the fractal frame memory. It snapshots the CPU-written pan/zoom registers at frame start and generates per-pixel complex coordinates incrementally. It restarts the frame whenever the parameters change, and reports busy status and a completed-frame count back to memory-mapped IO. It sits between memIO (params), the iteration core (start/done handshake) and fractmem (write port), all on clk50.

Parameters:
H_RES, 640, pixels per row
V_RES, 480, rows per frame
ADDR_W, 19, fractmem address width; H_RES*V_RES must be <= 2**ADDR_W

Ports:
clk  in  1  system clock (clk50 domain)
rst  in  1  reset; asynchronous, active-high
centerx  in  32  signed fixed-point pan X from memIO
centery  in  32  signed fixed-point pan Y from memIO
zoom  in  32  fixed-point step per pixel from memIO
core_start  out  1  one-cycle start pulse to the iteration core
core_cx  out  32  real coordinate of the current pixel, valid while core_start=1 and held until core_done
core_cy  out  32  imaginary coordinate of the current pixel, same validity as core_cx
core_done  in  1  one-cycle pulse from the core, no earlier than 1 cycle after core_start
core_pixel  in  1  result pixel, valid with core_done
write  out  1  one-cycle fractmem write strobe
write_pixel  out  1  pixel data for fractmem
write_addr  out  ADDR_W  fractmem address, linear row-major
busy  out  1  1 while a frame is being rendered
frame_count  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset values: core_start=0, core_cx=0, core_cy=0, write=0, write_pixel=0, write_addr=0, frame_count=0, busy=1. State is SETUP, so the first frame starts automatically after reset. Reset mid-frame aborts immediately; no write is issued.
- States: SETUP, ISSUE, WAIT, WRITE, IDLE. All outputs are registered.
- SETUP (1 cycle):
  - latch snapshot {centerx, centery, zoom}
  - x0 = centerx - zoom*(H_RES/2); y0 = centery - zoom*(V_RES/2), using integer division for H_RES/2 and V_RES/2; products are truncated to the low 32 bits and wrap mod 2^32
  - core_cx=x0, core_cy=y0, col=0, row=0, write_addr=0, busy=1
  - go to ISSUE
- ISSUE (1 cycle): if params differ from the snapshot -> SETUP. Otherwise assert core_start=1 for exactly this cycle -> WAIT.
- WAIT: hold core_cx/core_cy. On core_done:
  - if params changed since the snapshot (sticky restart flag, set any cycle from ISSUE onward) -> discard the pixel, SETUP
  - else latch write_pixel=core_pixel -> WRITE
- WRITE (1 cycle): write=1 with the current write_addr and write_pixel. Then advance:
  - col < H_RES-1: col++, core_cx += zoom
  - col = H_RES-1: col=0, core_cx=x0, row++, core_cy += zoom
  - write_addr++
  - last pixel (addr H_RES*V_RES-1): frame_count++, busy=0 -> IDLE; else -> ISSUE
- IDLE: busy=0, no strobes. Any param difference from the snapshot -> SETUP.
- Param change in the same cycle as core_done in WAIT counts as a change: the pixel is discarded.
- Throughput: minimum 3 cycles per pixel plus core latency. Write-to-next-start gap is exactly 1 cycle (ISSUE).
- write_addr never exceeds H_RES*V_RES-1; there is no wrap within a frame.
- core_done received outside WAIT is ignored.

Decomposition:
- Shared package: state encoding constants and the fixed-point format constants (integer/fraction split, shared with the iteration core).
- One natural sub-module: fract_coord_stepper. It holds x0/y0 and col/row counters and produces core_cx/core_cy/write_addr with load (SETUP) and step (WRITE) controls. The FSM stays in fract_render_sched.

Test Plan:
- Reset values: assert rst mid-cycle -> all outputs at reset values immediately. After release: SETUP, then core_start pulses 2 cycles later with core_cx = centerx - 320*zoom.
- Small full frame (H_RES=4, V_RES=3, centerx=100, centery=50, zoom=10; core model returns done 2 cycles after start, pixel=col[0]):
  - 12 writes at addr 0..11
  - core_cx sequence per row 80, 90, 100, 110; core_cy = 40, 50, 60 per row
  - pixels 0,1,0,1
  - frame_count=1, busy=0
- Mid-frame restart: change zoom to 20 during WAIT of pixel 5 -> that pixel is not written, next core_start has core_cx=60, core_cy=30, write_addr restarts at 0.
- Simultaneous change and done: zoom changes in the same cycle as core_done -> no write that cycle, SETUP next.
- IDLE retrigger: after frame complete, hold params 100 cycles -> no core_start. Change centerx -> new frame renders and frame_count increments to 2.
- Counter wrap: force frame_count=0xFFFF, complete a frame -> frame_count=0. Spurious core_done in IDLE -> no write.

Source files
------------

// File: rtl/fract_render_sched_pkg.sv
// rtl/fract_render_sched_pkg.sv - shared state encoding, fixed-point format and view snapshot type
package fract_render_sched_pkg;

    // Fixed-point split shared with the iteration core (signed Q4.28)
    localparam int FX_INT_BITS  = 4;
    localparam int FX_FRAC_BITS = 28;
    localparam int FX_WIDTH     = FX_INT_BITS + FX_FRAC_BITS;

    typedef enum logic [2:0] {
        ST_SETUP = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_IDLE  = 3'd4
    } state_t;

    // Pan/zoom view as written by the CPU; compared as a whole to detect changes
    typedef struct packed {
        logic [FX_WIDTH-1:0] centerx;
        logic [FX_WIDTH-1:0] centery;
        logic [FX_WIDTH-1:0] zoom;
    } view_t;

    // Coordinate of the first pixel on an axis: center minus half the span, wrapping mod 2^32
    function automatic logic [FX_WIDTH-1:0] fx_origin(
        input logic [FX_WIDTH-1:0] center,
        input logic [FX_WIDTH-1:0] step,
        input int unsigned         half
    );
        return center - step * FX_WIDTH'(half);
    endfunction

endpackage

// File: rtl/fract_render_sched_if.sv
// rtl/fract_render_sched_if.sv - params, iteration-core and frame-memory signals of the scheduler
interface fract_render_sched_if #(
    parameter int ADDR_W = 19
);
    import fract_render_sched_pkg::*;

    logic [FX_WIDTH-1:0] centerx;
    logic [FX_WIDTH-1:0] centery;
    logic [FX_WIDTH-1:0] zoom;
    logic                core_start;
    logic [FX_WIDTH-1:0] core_cx;
    logic [FX_WIDTH-1:0] core_cy;
    logic                core_done;
    logic                core_pixel;
    logic                write;
    logic                write_pixel;
    logic [ADDR_W-1:0]   write_addr;
    logic                busy;
    logic [15:0]         frame_count;

    modport master (
        output centerx, centery, zoom, core_done, core_pixel,
        input  core_start, core_cx, core_cy, write, write_pixel, write_addr, busy, frame_count
    );

    modport slave (
        input  centerx, centery, zoom, core_done, core_pixel,
        output core_start, core_cx, core_cy, write, write_pixel, write_addr, busy, frame_count
    );

endinterface

// File: rtl/fract_coord_stepper.sv
// rtl/fract_coord_stepper.sv - incremental per-pixel complex coordinate and linear address generator
module fract_coord_stepper
    import fract_render_sched_pkg::*;
#(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_step,
    input  logic [FX_WIDTH-1:0] i_centerx,
    input  logic [FX_WIDTH-1:0] i_centery,
    input  logic [FX_WIDTH-1:0] i_zoom,
    input  logic [FX_WIDTH-1:0] i_step_zoom,
    output logic [FX_WIDTH-1:0] o_cx,
    output logic [FX_WIDTH-1:0] o_cy,
    output logic [ADDR_W-1:0]   o_addr,
    output logic                o_last
);

    localparam int                COL_W     = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_RES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_RES * V_RES - 1);

    logic [FX_WIDTH-1:0] r_x0;
    logic [FX_WIDTH-1:0] r_cx;
    logic [FX_WIDTH-1:0] r_cy;
    logic [COL_W-1:0]    r_col;
    logic [ADDR_W-1:0]   r_addr;

    // Load the frame origin, or walk one pixel right (wrapping to the next row)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x0   <= '0;
            r_cx   <= '0;
            r_cy   <= '0;
            r_col  <= '0;
            r_addr <= '0;
        end else if (i_load) begin
            r_x0   <= fx_origin(i_centerx, i_zoom, H_RES / 2);
            r_cx   <= fx_origin(i_centerx, i_zoom, H_RES / 2);
            r_cy   <= fx_origin(i_centery, i_zoom, V_RES / 2);
            r_col  <= '0;
            r_addr <= '0;
        end else if (i_step) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_cx  <= r_x0;
                r_cy  <= r_cy + i_step_zoom;
            end else begin
                r_col <= r_col + 1'b1;
                r_cx  <= r_cx + i_step_zoom;
            end
            r_addr <= r_addr + 1'b1;
        end
    end

    assign o_cx   = r_cx;
    assign o_cy   = r_cy;
    assign o_addr = r_addr;
    assign o_last = (r_addr == ADDR_LAST);

endmodule

// File: rtl/fract_render_sched.sv
// rtl/fract_render_sched.sv - frame scheduler driving the iteration core and fractmem writes
module fract_render_sched
    import fract_render_sched_pkg::*;
#(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic               clk,
    input  logic               rst,
    fract_render_sched_if.slave bus
);

    state_t        r_state;
    state_t        w_state_nxt;
    view_t         r_snap;
    view_t         w_live;
    logic          w_diff;
    logic          r_restart;
    logic          w_load;
    logic          w_step;
    logic          w_start_nxt;
    logic          w_write_nxt;
    logic          w_last;
    logic          r_core_start;
    logic          r_write;
    logic          r_write_pixel;
    logic          r_busy;
    logic [15:0]   r_frame_count;
    logic [FX_WIDTH-1:0] w_cx;
    logic [FX_WIDTH-1:0] w_cy;
    logic [ADDR_W-1:0]   w_addr;

    assign w_live = {bus.centerx, bus.centery, bus.zoom};
    assign w_diff = (w_live != r_snap);

    fract_coord_stepper #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_stepper (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_centerx   (bus.centerx),
        .i_centery   (bus.centery),
        .i_zoom      (bus.zoom),
        .i_step_zoom (r_snap.zoom),
        .o_cx        (w_cx),
        .o_cy        (w_cy),
        .o_addr      (w_addr),
        .o_last      (w_last)
    );

    // State register; reset lands in SETUP so a frame starts on its own
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_SETUP;
        else     r_state <= w_state_nxt;
    end

    // Next state plus the decisions that get registered into the strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_start_nxt = 1'b0;
        w_write_nxt = 1'b0;
        case (r_state)
            ST_SETUP: begin
                w_load      = 1'b1;
                w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (w_diff || r_restart) begin
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_start_nxt = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.core_done) begin
                    if (w_diff || r_restart) begin
                        w_state_nxt = ST_SETUP;
                    end else begin
                        w_write_nxt = 1'b1;
                        w_state_nxt = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_step      = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_IDLE: begin
                if (w_diff) w_state_nxt = ST_SETUP;
            end
            default: w_state_nxt = ST_SETUP;
        endcase
    end

    // Registered strobes, view snapshot, sticky restart flag and frame status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_core_start  <= 1'b0;
            r_write       <= 1'b0;
            r_write_pixel <= 1'b0;
            r_busy        <= 1'b1;
            r_frame_count <= '0;
            r_snap        <= '0;
            r_restart     <= 1'b0;
        end else begin
            r_core_start <= w_start_nxt;
            r_write      <= w_write_nxt;
            if (w_write_nxt) r_write_pixel <= bus.core_pixel;
            if (r_state == ST_SETUP) begin
                r_snap    <= w_live;
                r_restart <= 1'b0;
            end else if (w_diff && r_state != ST_IDLE) begin
                r_restart <= 1'b1;
            end
            if (r_state == ST_WRITE && w_last) begin
                r_frame_count <= r_frame_count + 16'd1;
                r_busy        <= 1'b0;
            end
            if (r_state == ST_IDLE && w_diff) r_busy <= 1'b1;
        end
    end

    assign bus.core_start  = r_core_start;
    assign bus.core_cx     = w_cx;
    assign bus.core_cy     = w_cy;
    assign bus.write       = r_write;
    assign bus.write_pixel = r_write_pixel;
    assign bus.write_addr  = w_addr;
    assign bus.busy        = r_busy;
    assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_fract_render_sched.sv
// tb/tb_fract_render_sched.sv - self-checking bench for fract_render_sched on a 4x3 frame
module tb_fract_render_sched;
    import fract_render_sched_pkg::*;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    fract_render_sched_if #(.ADDR_W(AW)) bus();

    fract_render_sched #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cx;
        logic [31:0] cy;
        logic        pix;
    } st_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          pix;
    } wr_t;

    st_t  st_q[$];
    wr_t  wr_q[$];
    int   lat      = 2;
    bit   pix_rand = 0;
    int   n_starts = 0;
    bit   spur_req = 0;
    bit   pend     = 0;
    int   cnt      = 0;
    logic pend_pix = 1'b0;
    int   exp_fc   = 0;

    // Iteration-core model plus start/write recorder
    initial begin
        st_t s;
        wr_t w;
        bus.core_done  = 1'b0;
        bus.core_pixel = 1'b0;
        forever begin
            @(negedge clk);
            bus.core_done = 1'b0;
            if (rst) begin
                pend = 0;
            end else begin
                if (bus.write) begin
                    w.addr = bus.write_addr;
                    w.pix  = bus.write_pixel;
                    wr_q.push_back(w);
                end
                if (pend) begin
                    if (cnt == 0) begin
                        bus.core_done  = 1'b1;
                        bus.core_pixel = pend_pix;
                        pend = 0;
                    end else begin
                        cnt--;
                    end
                end
                if (spur_req) begin
                    bus.core_done  = 1'b1;
                    bus.core_pixel = 1'b1;
                    spur_req = 0;
                end
                if (bus.core_start) begin
                    pend     = 1;
                    cnt      = lat - 1;
                    pend_pix = pix_rand ? 1'($urandom_range(0, 1)) : n_starts[0];
                    n_starts++;
                    s.cx  = bus.core_cx;
                    s.cy  = bus.core_cy;
                    s.pix = pend_pix;
                    st_q.push_back(s);
                end
            end
        end
    end

    // Reference coordinate straight from the view: center + zoom*(index - half)
    function automatic logic [31:0] ref_coord(input logic [31:0] c, input logic [31:0] z,
                                              input int idx, input int half);
        logic [31:0] d;
        d = 32'(idx - half);
        return c + z * d;
    endfunction

    task automatic clear_log();
        st_q.delete();
        wr_q.delete();
        n_starts = 0;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        @(negedge clk); #1;
        while (bus.busy !== 1'b0 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s timeout: busy=%b after %0d cycles, expected 0", name, bus.busy, n);
        end
    endtask

    task automatic check_seq(input string name, input logic [31:0] cx, input logic [31:0] cy,
                             input logic [31:0] z, input int st_off, input int wr_off, input int n);
        st_t s;
        wr_t w;
        logic [31:0] ecx, ecy;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (st_off + k >= st_q.size() || wr_off + k >= wr_q.size()) begin
                errors++;
                $display("FAIL %s px%0d missing: starts=%0d writes=%0d", name, k, st_q.size(), wr_q.size());
            end else begin
                s   = st_q[st_off + k];
                w   = wr_q[wr_off + k];
                ecx = ref_coord(cx, z, k % H, H / 2);
                ecy = ref_coord(cy, z, k / H, V / 2);
                if (s.cx !== ecx || s.cy !== ecy || w.addr !== AW'(k) || w.pix !== s.pix) begin
                    errors++;
                    $display("FAIL %s px%0d: cx=%0h cy=%0h addr=%0d pix=%b, expected cx=%0h cy=%0h addr=%0d pix=%b",
                             name, k, s.cx, s.cy, w.addr, w.pix, ecx, ecy, k, s.pix);
                end
            end
        end
    endtask

    task automatic check_counts(input string name, input int n_st, input int n_wr);
        checks++;
        if (st_q.size() != n_st || wr_q.size() != n_wr || bus.frame_count !== 16'(exp_fc)) begin
            errors++;
            $display("FAIL %s counts: starts=%0d writes=%0d frames=%0d, expected %0d %0d %0d",
                     name, st_q.size(), wr_q.size(), bus.frame_count, n_st, n_wr, exp_fc);
        end
    endtask

    task automatic test_reset();
        bus.centerx = 32'd100;
        bus.centery = 32'd50;
        bus.zoom    = 32'd10;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.core_start !== 1'b0 || bus.write !== 1'b0 || bus.write_pixel !== 1'b0 ||
            bus.busy !== 1'b1 || bus.core_cx !== 32'd0 || bus.core_cy !== 32'd0 ||
            bus.write_addr !== '0 || bus.frame_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_async: start=%b write=%b pix=%b busy=%b cx=%0h cy=%0h addr=%0d fc=%0d, expected 0 0 0 1 0 0 0 0",
                     bus.core_start, bus.write, bus.write_pixel, bus.busy, bus.core_cx, bus.core_cy,
                     bus.write_addr, bus.frame_count);
        end
        clear_log();
        @(negedge clk); #1;
        checks++;
        if (bus.write !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_write: write=%b expected 0", bus.write);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus.core_start !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_setup: start=%b busy=%b, expected 0 1", bus.core_start, bus.busy);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.core_start !== 1'b1 || bus.core_cx !== 32'd80 || bus.core_cy !== 32'd40 || bus.write_addr !== '0) begin
            errors++;
            $display("FAIL reset_first_start: start=%b cx=%0d cy=%0d addr=%0d, expected 1 80 40 0",
                     bus.core_start, bus.core_cx, bus.core_cy, bus.write_addr);
        end
    endtask

    task automatic test_full_frame();
        wait_frame("full_frame");
        exp_fc = 1;
        check_counts("full_frame", 12, 12);
        check_seq("full_frame", 32'd100, 32'd50, 32'd10, 0, 0, 12);
        for (int k = 0; k < 12 && k < wr_q.size(); k++) begin
            checks++;
            if (wr_q[k].pix !== 1'(k % 2)) begin
                errors++;
                $display("FAIL full_frame_pix px%0d: pix=%b expected %b", k, wr_q[k].pix, 1'(k % 2));
            end
        end
    endtask

    task automatic test_restart();
        int n;
        clear_log();
        bus.zoom = 32'd30;
        n = 0;
        while (st_q.size() < 6 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        bus.zoom = 32'd20;
        wait_frame("restart");
        exp_fc = 2;
        check_counts("restart", 18, 17);
        check_seq("restart_pre", 32'd100, 32'd50, 32'd30, 0, 0, 5);
        checks++;
        if (st_q.size() < 7 || st_q[5].cx !== 32'd70 || st_q[6].cx !== 32'd60 || st_q[6].cy !== 32'd30) begin
            errors++;
            $display("FAIL restart_coord: starts=%0d, expected start5 cx=70 then cx=60 cy=30", st_q.size());
        end
        check_seq("restart_post", 32'd100, 32'd50, 32'd20, 6, 5, 12);
    endtask

    task automatic test_simultaneous();
        int  n;
        bit  seen;
        clear_log();
        bus.zoom = 32'd10;
        n = 0;
        while (st_q.size() < 3 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            if (bus.core_done) seen = 1;
        end
        bus.zoom = 32'd20;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL simul_done_timeout: done seen=%b expected 1", seen);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.write !== 1'b0) begin
            errors++;
            $display("FAIL simul_no_write: write=%b expected 0", bus.write);
        end
        wait_frame("simul");
        exp_fc = 3;
        check_counts("simul", 15, 14);
        check_seq("simul_pre", 32'd100, 32'd50, 32'd10, 0, 0, 2);
        check_seq("simul_post", 32'd100, 32'd50, 32'd20, 3, 2, 12);
    endtask

    task automatic test_idle_retrigger();
        int starts, writes;
        starts = 0;
        writes = 0;
        repeat (100) begin
            @(negedge clk); #1;
            if (bus.core_start) starts++;
            if (bus.write) writes++;
        end
        checks++;
        if (starts != 0 || writes != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: starts=%0d writes=%0d busy=%b, expected 0 0 0", starts, writes, bus.busy);
        end
        clear_log();
        bus.centerx = 32'd200;
        wait_frame("idle_retrigger");
        exp_fc = 4;
        check_counts("idle_retrigger", 12, 12);
        check_seq("idle_retrigger", 32'd200, 32'd50, 32'd20, 0, 0, 12);
    endtask

    task automatic test_wrap();
        int starts, writes;
        force dut.r_frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_count;
        #1;
        checks++;
        if (bus.frame_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preset: fc=%0h expected ffff", bus.frame_count);
        end
        spur_req = 1;
        starts = 0;
        writes = 0;
        repeat (5) begin
            @(negedge clk); #1;
            if (bus.core_start) starts++;
            if (bus.write) writes++;
        end
        checks++;
        if (starts != 0 || writes != 0) begin
            errors++;
            $display("FAIL spurious_done: starts=%0d writes=%0d, expected 0 0", starts, writes);
        end
        clear_log();
        bus.centery = 32'd77;
        wait_frame("wrap");
        exp_fc = 0;
        check_counts("wrap", 12, 12);
        check_seq("wrap", 32'd200, 32'd77, 32'd20, 0, 0, 12);
    endtask

    task automatic test_random();
        logic [31:0] cx, cy, z;
        pix_rand = 1;
        for (int f = 0; f < 5; f++) begin
            lat = int'($urandom_range(1, 4));
            cx  = $urandom;
            cy  = $urandom;
            z   = $urandom;
            if (cx == bus.centerx) cx = cx ^ 32'd1;
            clear_log();
            bus.centerx = cx;
            bus.centery = cy;
            bus.zoom    = z;
            wait_frame("random");
            exp_fc = (exp_fc + 1) % 65536;
            check_counts("random", 12, 12);
            check_seq("random", cx, cy, z, 0, 0, 12);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_restart();
        test_simultaneous();
        test_idle_retrigger();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
